// File: rtl/tc_sram_arb_pkg.sv
// Shared types and helpers for the round-robin SRAM port arbiter.
package tc_sram_arb_pkg;

  // Widest requester index a response entry can carry (up to 256 requesters).
  localparam int IdxMax = 8;

  function automatic int idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic              valid;
    logic [IdxMax-1:0] idx;
  } rsp_entry_t;

endpackage

// File: rtl/tc_sram_arb_rr.sv
// Rotate-priority pick: first requester at or above the pointer wins, else wrap to the bottom.
module tc_sram_arb_rr
  import tc_sram_arb_pkg::*;
#(
  parameter  int NumReq   = 4,
  localparam int IdxWidth = idx_width(NumReq)
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxWidth'(i);
      end
    end
    // Wrapped half of the search: indices below the pointer.
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_i[i] && (i < int'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/tc_sram_arbiter.sv
// Shares one single-port SRAM among NumReq requesters with round-robin grant,
// optional burst lock and a read-latency tracker that routes rvalid back to the issuer.
module tc_sram_arbiter
  import tc_sram_arb_pkg::*;
#(
  parameter  int NumReq    = 4,
  parameter  int AddrWidth = 10,
  parameter  int DataWidth = 32,
  parameter  int ByteWidth = 8,
  parameter  int Latency   = 1,
  localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int IdxWidth  = idx_width(NumReq)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0]                    lock_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]       be_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [AddrWidth-1:0]                 sram_addr_o,
  output logic [DataWidth-1:0]                 sram_wdata_o,
  output logic [BeWidth-1:0]                   sram_be_o,
  input  logic [DataWidth-1:0]                 sram_rdata_i
);

  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic                locked_q, locked_d;
  logic [NumReq-1:0]   rr_gnt;
  logic [IdxWidth-1:0] rr_idx;
  logic [IdxWidth-1:0] win_idx;
  logic                accept;
  rsp_entry_t          rsp_in;
  rsp_entry_t          rsp_out;

  tc_sram_arb_rr #(
    .NumReq(NumReq)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (rr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  // A held lock masks the round-robin pick; an idle lock owner stalls everyone.
  always_comb begin
    gnt_o   = '0;
    win_idx = rr_idx;
    if (locked_q) begin
      win_idx = lock_idx_q;
      if (req_i[lock_idx_q]) gnt_o[lock_idx_q] = 1'b1;
    end else begin
      gnt_o = rr_gnt;
    end
    accept = |gnt_o;
  end

  always_comb begin
    sram_req_o   = accept;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (accept) begin
      sram_we_o    = we_i[win_idx];
      sram_addr_o  = addr_i[win_idx];
      sram_wdata_o = wdata_i[win_idx];
      sram_be_o    = be_i[win_idx];
    end
  end

  always_comb begin
    rr_d       = rr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      rr_d       = (win_idx == IdxWidth'(NumReq - 1)) ? '0 : win_idx + IdxWidth'(1);
      locked_d   = lock_i[win_idx];
      lock_idx_d = win_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept && !we_i[win_idx];
    rsp_in.idx   = IdxMax'(win_idx);
  end

  if (Latency == 0) begin : g_comb
    assign rsp_out = rsp_in;
  end else begin : g_pipe
    rsp_entry_t pipe_q [Latency];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < Latency; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= rsp_in;
        for (int i = 1; i < Latency; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign rsp_out = pipe_q[Latency-1];
  end

  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      rvalid_o[i] = rsp_out.valid && (rsp_out.idx == IdxMax'(i));
    end
  end

  // Read data is the macro's output, aligned with rvalid by the pipeline depth.
  assign rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_tc_sram_arbiter.sv
// Bench for tc_sram_arbiter: Latency=1 and Latency=2 instances share stimulus,
// each with its own behavioural SRAM and response scoreboard.
module tb_tc_sram_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_i;
  logic [N-1:0]           req_i, lock_i, we_i;
  logic [N-1:0][AW-1:0]   addr_i;
  logic [N-1:0][DW-1:0]   wdata_i;
  logic [N-1:0][BW-1:0]   be_i;

  logic [N-1:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          sreq_a, swe_a, sreq_b, swe_b;
  logic [AW-1:0] saddr_a, saddr_b;
  logic [DW-1:0] swdata_a, swdata_b, srdata_a, srdata_b, stage_b;
  logic [BW-1:0] sbe_a, sbe_b;

  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];

  tc_sram_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .ByteWidth(8), .Latency(1)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_a),
    .rvalid_o(rvalid_a), .rdata_o(rdata_a), .sram_req_o(sreq_a), .sram_we_o(swe_a),
    .sram_addr_o(saddr_a), .sram_wdata_o(swdata_a), .sram_be_o(sbe_a),
    .sram_rdata_i(srdata_a)
  );

  tc_sram_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .ByteWidth(8), .Latency(2)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_b),
    .rvalid_o(rvalid_b), .rdata_o(rdata_b), .sram_req_o(sreq_b), .sram_we_o(swe_b),
    .sram_addr_o(saddr_b), .sram_wdata_o(swdata_b), .sram_be_o(sbe_b),
    .sram_rdata_i(srdata_b)
  );

  // Behavioural macros: byte-masked write, read data after 1 or 2 cycles.
  always @(posedge clk) begin
    if (sreq_a) begin
      if (swe_a) begin
        for (int b = 0; b < BW; b++)
          if (sbe_a[b]) mem_a[saddr_a][b*8 +: 8] <= swdata_a[b*8 +: 8];
      end else begin
        srdata_a <= mem_a[saddr_a];
      end
    end
  end

  always @(posedge clk) begin
    if (sreq_b) begin
      if (swe_b) begin
        for (int b = 0; b < BW; b++)
          if (sbe_b[b]) mem_b[saddr_b][b*8 +: 8] <= swdata_b[b*8 +: 8];
      end else begin
        stage_b <= mem_b[saddr_b];
      end
    end
    srdata_b <= stage_b;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [N+DW-1:0] exp_q_a[$];
  logic [N+DW-1:0] exp_q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [N+DW-1:0] e;
    if (mon_en) begin
      if (rvalid_a !== '0) begin
        if (exp_q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_l1 unexpected: rvalid %b expected none", rvalid_a);
        end else begin
          e = exp_q_a.pop_front();
          chk("rsp_l1", {rvalid_a, rdata_a}, e);
        end
      end
      if (rvalid_b !== '0) begin
        if (exp_q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_l2 unexpected: rvalid %b expected none", rvalid_b);
        end else begin
          e = exp_q_b.pop_front();
          chk("rsp_l2", {rvalid_b, rdata_b}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic to_a, input logic to_b, input logic [N-1:0] rv, input logic [DW-1:0] d);
    if (to_a) exp_q_a.push_back({rv, d});
    if (to_b) exp_q_b.push_back({rv, d});
  endtask

  task automatic clr();
    req_i  = '0;
    lock_i = '0;
    we_i   = '0;
  endtask

  task automatic cyc(input string name, input logic [N-1:0] exp_gnt);
    @(negedge clk);
    chk({name, " gnt_l1"}, 64'(gnt_a), 64'(exp_gnt));
    chk({name, " gnt_l2"}, 64'(gnt_b), 64'(exp_gnt));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) cyc("idle", 4'b0000);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [DW-1:0] W5 = 32'hDEADBEEF;
  localparam logic [DW-1:0] W3 = 32'hA5A50003;
  localparam logic [DW-1:0] W4 = 32'h5A5A0004;

  logic [N-1:0] fair_seq [6];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[5] = W5; mem_b[5] = W5;
    mem_a[3] = W3; mem_b[3] = W3;
    mem_a[4] = W4; mem_b[4] = W4;
    fair_seq[0] = 4'b0001; fair_seq[1] = 4'b0010; fair_seq[2] = 4'b0100;
    fair_seq[3] = 4'b1000; fair_seq[4] = 4'b0001; fair_seq[5] = 4'b0010;

    rst_i   = 1'b1;
    clr();
    addr_i  = '0;
    wdata_i = '0;
    be_i    = '0;

    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset gnt_l1", 64'(gnt_a), 64'h0);
    chk("reset gnt_l2", 64'(gnt_b), 64'h0);
    chk("reset rvalid_l1", 64'(rvalid_a), 64'h0);
    chk("reset rvalid_l2", 64'(rvalid_b), 64'h0);
    chk("reset sram_req", 64'({sreq_a, sreq_b}), 64'h0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Single read of word 5 by requester 0.
    req_i = 4'b0001; addr_i[0] = 10'd5;
    push(1, 1, 4'b0001, W5);
    cyc("single_read", 4'b0001);
    idle(3);

    // Masked write by requester 2 (pointer now 1), no response expected.
    req_i = 4'b0100; we_i[2] = 1'b1; addr_i[2] = 10'd9;
    wdata_i[2] = 32'h12345678; be_i[2] = 4'b0011;
    cyc("write", 4'b0100);
    clr();
    req_i = 4'b0001; addr_i[0] = 10'd9;
    push(1, 1, 4'b0001, 32'h00005678);
    cyc("read_back", 4'b0001);
    idle(3);

    // Fairness from reset with back-to-back reads.
    rst_i = 1'b1;
    cyc("rst_fair", 4'b0000);
    rst_i = 1'b0;
    for (int i = 0; i < N; i++) addr_i[i] = 10'd5;
    req_i = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      push(1, 1, fair_seq[k], W5);
      cyc("fair", fair_seq[k]);
    end

    // Move the pointer to 1, then lock requester 1.
    req_i = 4'b0001;
    push(1, 1, 4'b0001, W5);
    cyc("pre_lock", 4'b0001);
    req_i = 4'b1111; lock_i = 4'b0010;
    push(1, 1, 4'b0010, W5);
    cyc("lock_g1", 4'b0010);
    push(1, 1, 4'b0010, W5);
    cyc("lock_g2", 4'b0010);
    req_i = 4'b1101;
    cyc("lock_hold", 4'b0000);
    req_i = 4'b1111; lock_i = 4'b0000;
    push(1, 1, 4'b0010, W5);
    cyc("lock_g3", 4'b0010);
    lock_i = 4'b1000;
    push(1, 1, 4'b0100, W5);
    cyc("after_lock", 4'b0100);
    lock_i = 4'b0000; req_i = 4'b0011;
    push(1, 1, 4'b0001, W5);
    cyc("wrap", 4'b0001);
    idle(3);

    // Ordering of consecutive reads from different requesters.
    req_i = 4'b0010; addr_i[1] = 10'd3;
    push(1, 1, 4'b0010, W3);
    cyc("order_r1", 4'b0010);
    req_i = 4'b1000; addr_i[3] = 10'd4;
    push(1, 1, 4'b1000, W4);
    cyc("order_r3", 4'b1000);
    idle(3);

    // Reset one cycle after a read: only the Latency=1 response escapes.
    req_i = 4'b0001; addr_i[0] = 10'd5;
    push(1, 0, 4'b0001, W5);
    cyc("mf_read", 4'b0001);
    clr();
    rst_i = 1'b1;
    cyc("mf_rst", 4'b0000);
    rst_i = 1'b0;
    cyc("mf_idle", 4'b0000);
    for (int i = 0; i < N; i++) addr_i[i] = 10'd5;
    req_i = 4'b1111;
    push(1, 1, 4'b0001, W5);
    cyc("post_rst", 4'b0001);
    idle(4);

    chk("drain_l1", 64'(exp_q_a.size()), 64'h0);
    chk("drain_l2", 64'(exp_q_b.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
